// File: rtl/uart_pkg.sv
// Shared UART definitions: divisor calculation, parity mode names and RX state encoding.
package uart_pkg;

   localparam string PAR_NONE = "NONE";
   localparam string PAR_ODD  = "ODD";
   localparam string PAR_EVEN = "EVEN";

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } rx_state_t;

   // Clocks per bit; shared with the transmitter so both ends agree exactly
   function automatic logic [15:0] baud_div(input int unsigned sys_clk_period,
                                            input int unsigned baud_rate);
      return 16'(32'd1_000_000_000 / sys_clk_period / baud_rate);
   endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Brings the asynchronous serial line into the CLK_I domain and flags falling edges.
module uart_rx_sync (
   input  logic CLK_I,
   input  logic RST_I,
   input  logic UART_I,
   output logic rx_s,
   output logic fall_edge
);

   logic meta;
   logic rx_d;

   // Reset to the idle-high line level so reset itself never looks like a start bit
   always_ff @(posedge CLK_I) begin
      if (RST_I) begin
         meta <= 1'b1;
         rx_s <= 1'b1;
         rx_d <= 1'b1;
      end else begin
         meta <= UART_I;
         rx_s <= meta;
         rx_d <= rx_s;
      end
   end

   assign fall_edge = ~rx_s & rx_d;

endmodule

// File: rtl/uart_rx.sv
// 8-bit UART receiver: start, 8 data LSB-first, optional parity, 1 stop; mid-bit sampling.
module uart_rx
   import uart_pkg::*;
#(
   parameter int unsigned SYS_CLK_PERIOD = 50,
   parameter int unsigned BAUD_RATE      = 115200,
   parameter string       PRIOTY         = "EVEN"
) (
   input  logic       CLK_I,
   input  logic       RST_I,
   input  logic       UART_I,
   output logic [7:0] PDATA_O,
   output logic       DONE_O,
   output logic       PARITY_ERR_O,
   output logic       FRAME_ERR_O,
   output logic       BUSY_O
);

   localparam logic [15:0] BAUD_DIV = baud_div(SYS_CLK_PERIOD, BAUD_RATE);
   localparam logic [15:0] BIT_LAST = BAUD_DIV - 16'd1;
   localparam logic [15:0] HALF_LAST = (BAUD_DIV >> 1) - 16'd1;
   localparam logic PAR_EN   = (PRIOTY != PAR_NONE);
   localparam logic ODD_MODE = (PRIOTY == PAR_ODD);

   logic rx_s;
   logic fall_edge;

   uart_rx_sync u_sync (
      .CLK_I    (CLK_I),
      .RST_I    (RST_I),
      .UART_I   (UART_I),
      .rx_s     (rx_s),
      .fall_edge(fall_edge)
   );

   rx_state_t   state, state_nxt;
   logic [15:0] cnt, cnt_nxt;
   logic [2:0]  bit_idx, bit_idx_nxt;
   logic [7:0]  shift, shift_nxt;
   logic        par_bit, par_bit_nxt;
   logic [7:0]  pdata_nxt;
   logic        done_nxt;
   logic        perr_nxt;
   logic        ferr_nxt;
   logic        busy_nxt;

   always_ff @(posedge CLK_I) begin
      if (RST_I) begin
         state        <= IDLE;
         cnt          <= '0;
         bit_idx      <= '0;
         shift        <= '0;
         par_bit      <= 1'b0;
         PDATA_O      <= '0;
         DONE_O       <= 1'b0;
         PARITY_ERR_O <= 1'b0;
         FRAME_ERR_O  <= 1'b0;
         BUSY_O       <= 1'b0;
      end else begin
         state        <= state_nxt;
         cnt          <= cnt_nxt;
         bit_idx      <= bit_idx_nxt;
         shift        <= shift_nxt;
         par_bit      <= par_bit_nxt;
         PDATA_O      <= pdata_nxt;
         DONE_O       <= done_nxt;
         PARITY_ERR_O <= perr_nxt;
         FRAME_ERR_O  <= ferr_nxt;
         BUSY_O       <= busy_nxt;
      end
   end

   // Counter restarts at every sample point so each bit is timed from the previous sample
   always_comb begin
      state_nxt   = state;
      cnt_nxt     = 16'(cnt + 16'd1);
      bit_idx_nxt = bit_idx;
      shift_nxt   = shift;
      par_bit_nxt = par_bit;
      pdata_nxt   = PDATA_O;
      done_nxt    = 1'b0;
      perr_nxt    = PARITY_ERR_O;
      ferr_nxt    = FRAME_ERR_O;

      case (state)
         IDLE: begin
            cnt_nxt = '0;
            if (fall_edge) begin
               state_nxt = START;
            end
         end
         START: begin
            if (cnt == HALF_LAST) begin
               cnt_nxt     = '0;
               bit_idx_nxt = '0;
               state_nxt   = rx_s ? IDLE : DATA;
            end
         end
         DATA: begin
            if (cnt == BIT_LAST) begin
               cnt_nxt     = '0;
               shift_nxt   = {rx_s, shift[7:1]};
               bit_idx_nxt = 3'(bit_idx + 3'd1);
               if (bit_idx == 3'd7) begin
                  state_nxt = PAR_EN ? PARITY : STOP;
               end
            end
         end
         PARITY: begin
            if (cnt == BIT_LAST) begin
               cnt_nxt     = '0;
               par_bit_nxt = rx_s;
               state_nxt   = STOP;
            end
         end
         STOP: begin
            // Finish at mid-stop so a shortened stop bit still leaves time for the next start
            if (cnt == BIT_LAST) begin
               cnt_nxt   = '0;
               done_nxt  = 1'b1;
               pdata_nxt = shift;
               ferr_nxt  = ~rx_s;
               perr_nxt  = PAR_EN & (par_bit ^ (^shift) ^ ODD_MODE);
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
         end
      endcase

      busy_nxt = (state_nxt != IDLE);
   end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: an EVEN and an ODD instance share one serial line.
`timescale 1ns/1ps
module tb_uart_rx;

   localparam int BIT = 173;
   localparam int LAT = 1819;   // start-bit drive cycle to DONE_O cycle (2 sync + 86 + 10*173 + 1)

   typedef struct {
      logic [7:0] d;
      logic       pe;
      logic       fe;
      int         cyc;
   } rec_t;

   typedef struct {
      logic [7:0] d;
      logic       p;
      int         stop_len;
      logic       pe_e;
      logic       pe_o;
   } vec_t;

   logic CLK_I  = 1'b0;
   logic RST_I  = 1'b1;
   logic UART_I = 1'b1;

   logic [7:0] pdata_e, pdata_o;
   logic       done_e, done_o, perr_e, perr_o, ferr_e, ferr_o, busy_e, busy_o;

   uart_rx dut_even (
      .CLK_I(CLK_I), .RST_I(RST_I), .UART_I(UART_I),
      .PDATA_O(pdata_e), .DONE_O(done_e), .PARITY_ERR_O(perr_e),
      .FRAME_ERR_O(ferr_e), .BUSY_O(busy_e)
   );

   uart_rx #(.PRIOTY("ODD")) dut_odd (
      .CLK_I(CLK_I), .RST_I(RST_I), .UART_I(UART_I),
      .PDATA_O(pdata_o), .DONE_O(done_o), .PARITY_ERR_O(perr_o),
      .FRAME_ERR_O(ferr_o), .BUSY_O(busy_o)
   );

   always #25 CLK_I = ~CLK_I;

   int cyc = 0;
   always @(posedge CLK_I) cyc <= cyc + 1;

   rec_t q_e[$];
   rec_t q_o[$];

   always @(negedge CLK_I) begin
      if (done_e) q_e.push_back('{pdata_e, perr_e, ferr_e, cyc});
      if (done_o) q_o.push_back('{pdata_o, perr_o, ferr_o, cyc});
   end

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic hold(input int n);
      repeat (n) @(posedge CLK_I);
      #1;
   endtask

   // Caller is aligned one time unit after a rising edge
   task automatic send_frame(input logic [7:0] d, input logic p, input logic s,
                             input int stop_len, output int st);
      st = cyc;
      UART_I = 1'b0;
      hold(BIT);
      for (int i = 0; i < 8; i++) begin
         UART_I = d[i];
         hold(BIT);
      end
      UART_I = p;
      hold(BIT);
      UART_I = s;
      hold(stop_len);
   endtask

   task automatic chk_rec(input string tag, input bit odd, input int idx,
                          input logic [7:0] d, input logic pe, input logic fe,
                          input int exp_cyc);
      rec_t r;
      int   sz;
      sz = odd ? q_o.size() : q_e.size();
      if (idx >= sz) begin
         chk({tag, " present"}, 0, 1);
      end else begin
         r = odd ? q_o[idx] : q_e[idx];
         chk({tag, " data"}, int'(r.d), int'(d));
         chk({tag, " perr"}, int'(r.pe), int'(pe));
         chk({tag, " ferr"}, int'(r.fe), int'(fe));
         if (exp_cyc >= 0) chk({tag, " done_cycle"}, r.cyc, exp_cyc);
      end
   endtask

   task automatic chk_idle_outputs(input string tag);
      chk({tag, " pdata_e"}, int'(pdata_e), 0);
      chk({tag, " done_e"},  int'(done_e), 0);
      chk({tag, " perr_e"},  int'(perr_e), 0);
      chk({tag, " ferr_e"},  int'(ferr_e), 0);
      chk({tag, " busy_e"},  int'(busy_e), 0);
      chk({tag, " pdata_o"}, int'(pdata_o), 0);
      chk({tag, " perr_o"},  int'(perr_o), 0);
      chk({tag, " ferr_o"},  int'(ferr_o), 0);
      chk({tag, " busy_o"},  int'(busy_o), 0);
   endtask

   initial begin
      #(64'd4_500_000);
      $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t tbl[7];
      int   st[7];
      int   st2;
      int   nbusy;

      // data, parity bit sent, stop length, expected perr EVEN / ODD
      tbl[0] = '{8'h55, 1'b0, 173, 1'b0, 1'b1};
      tbl[1] = '{8'hA5, 1'b0, 173, 1'b0, 1'b1};
      tbl[2] = '{8'hA5, 1'b1, 171, 1'b1, 1'b0};
      tbl[3] = '{8'h00, 1'b0, 171, 1'b0, 1'b1};
      tbl[4] = '{8'hFF, 1'b0, 171, 1'b0, 1'b1};
      tbl[5] = '{8'h80, 1'b0,  90, 1'b1, 1'b0};
      tbl[6] = '{8'h3C, 1'b1, 173, 1'b1, 1'b0};

      RST_I = 1'b1;
      repeat (3) @(posedge CLK_I);
      #1;
      RST_I = 1'b0;
      @(negedge CLK_I);
      chk_idle_outputs("reset");
      @(posedge CLK_I);
      #1;
      hold(20);

      // Back-to-back frames, some with shortened stop bits
      q_e.delete(); q_o.delete();
      for (int i = 0; i < 7; i++) begin
         send_frame(tbl[i].d, tbl[i].p, 1'b1, tbl[i].stop_len, st[i]);
      end
      hold(300);
      chk("table count even", q_e.size(), 7);
      chk("table count odd",  q_o.size(), 7);
      for (int i = 0; i < 7; i++) begin
         chk_rec($sformatf("row%0d even", i), 1'b0, i, tbl[i].d, tbl[i].pe_e, 1'b0, st[i] + LAT);
         chk_rec($sformatf("row%0d odd", i),  1'b1, i, tbl[i].d, tbl[i].pe_o, 1'b0, st[i] + LAT);
      end

      // 40-cycle low glitch: BUSY_O for cycles t0+1..t0+86, no frame
      q_e.delete(); q_o.delete();
      nbusy = 0;
      UART_I = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge CLK_I);
         if (i == 40) UART_I = 1'b1;
         if (busy_e) nbusy++;
      end
      chk("glitch busy cycles", nbusy, 86);
      chk("glitch busy end", int'(busy_e), 0);
      chk("glitch done count", q_e.size() + q_o.size(), 0);
      @(posedge CLK_I);
      #1;
      hold(20);

      // Stop bit low then line held low; recovery after the line goes high
      q_e.delete(); q_o.delete();
      send_frame(8'h3C, 1'b0, 1'b0, BIT, st2);
      hold(2 * 1903);
      UART_I = 1'b1;
      hold(200);
      send_frame(8'h81, 1'b0, 1'b1, BIT, st2);
      hold(300);
      chk("ferr count even", q_e.size(), 2);
      chk("ferr count odd",  q_o.size(), 2);
      chk_rec("ferr even",  1'b0, 0, 8'h3C, 1'b0, 1'b1, -1);
      chk_rec("ferr odd",   1'b1, 0, 8'h3C, 1'b1, 1'b1, -1);
      chk_rec("after even", 1'b0, 1, 8'h81, 1'b0, 1'b0, st2 + LAT);
      chk_rec("after odd",  1'b1, 1, 8'h81, 1'b1, 1'b0, st2 + LAT);

      // Reset during data bit 4 of 0x5A abandons the frame
      q_e.delete(); q_o.delete();
      begin
         logic [7:0] b5a;
         b5a = 8'h5A;
         UART_I = 1'b0;
         hold(BIT);
         for (int i = 0; i < 4; i++) begin
            UART_I = b5a[i];
            hold(BIT);
         end
         UART_I = b5a[4];
         hold(80);
      end
      RST_I = 1'b1;
      hold(1);
      RST_I = 1'b0;
      @(negedge CLK_I);
      chk_idle_outputs("midframe reset");
      @(posedge CLK_I);
      #1;
      UART_I = 1'b1;
      hold(1500);
      chk("abandoned frame done", q_e.size() + q_o.size(), 0);
      send_frame(8'hC3, 1'b0, 1'b1, BIT, st2);
      hold(300);
      chk("post reset count", q_e.size(), 1);
      chk_rec("post reset even", 1'b0, 0, 8'hC3, 1'b0, 1'b0, st2 + LAT);
      chk_rec("post reset odd",  1'b1, 0, 8'hC3, 1'b1, 1'b0, st2 + LAT);

      // Break from idle: one frame error with zero data, nothing more while low
      q_e.delete(); q_o.delete();
      UART_I = 1'b0;
      hold(3000);
      chk("break busy while low", int'(busy_e), 0);
      UART_I = 1'b1;
      hold(300);
      chk("break count even", q_e.size(), 1);
      chk("break count odd",  q_o.size(), 1);
      chk_rec("break even", 1'b0, 0, 8'h00, 1'b0, 1'b1, -1);
      chk_rec("break odd",  1'b1, 0, 8'h00, 1'b1, 1'b1, -1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
